// File: rtl/quad_decoder.sv
// Quadrature decoder: synchronises and glitch-filters A/B, decodes Gray-code steps
// into up/down/err pulses and maintains a loadable wrapping position register.
module quad_decoder #(
  parameter int DATA_WIDTH    = 8,
  parameter int FILTER_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enc_a,
  input  logic                  enc_b,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  up,
  output logic                  down,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] dout
);

  typedef enum logic {INIT, TRACK} state_t;

  localparam logic [7:0] FILT_LAST = 8'(FILTER_CYCLES - 1);
  localparam logic [8:0] INIT_LAST = 9'(FILTER_CYCLES + 1);

  state_t                state_q, state_d;
  logic [8:0]            init_cnt_q, init_cnt_d;
  logic [1:0]            sync1_q, sync1_d;
  logic [1:0]            sync2_q, sync2_d;
  logic [1:0]            f_q, f_d;
  logic [1:0][7:0]       fcnt_q, fcnt_d;
  logic [1:0]            prev_q, prev_d;
  logic                  up_q, up_d;
  logic                  down_q, down_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;

  // Channel bit 1 is A, bit 0 is B throughout.
  always_comb begin
    sync1_d    = {enc_a, enc_b};
    sync2_d    = sync1_q;
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    f_d        = f_q;
    fcnt_d     = fcnt_q;
    prev_d     = f_q;
    up_d       = 1'b0;
    down_d     = 1'b0;
    err_d      = 1'b0;
    dout_d     = dout_q;

    if (state_q == INIT) begin
      // Filters follow the pins directly so TRACK starts from a settled reference.
      f_d    = sync2_q;
      fcnt_d = '0;
      if (init_cnt_q == INIT_LAST) begin
        state_d = TRACK;
      end else begin
        init_cnt_d = init_cnt_q + 9'd1;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == f_q[i]) begin
          fcnt_d[i] = '0;
        end else if (fcnt_q[i] == FILT_LAST) begin
          f_d[i]    = sync2_q[i];
          fcnt_d[i] = '0;
        end else begin
          fcnt_d[i] = fcnt_q[i] + 8'd1;
        end
      end

      case ({prev_q, f_q})
        4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: up_d   = 1'b1;
        4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: down_d = 1'b1;
        4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: err_d  = 1'b1;
        default: ;
      endcase
    end

    if (load) begin
      dout_d = din;
    end else if (up_d) begin
      dout_d = dout_q + DATA_WIDTH'(1);
    end else if (down_d) begin
      dout_d = dout_q - DATA_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      f_q        <= '0;
      fcnt_q     <= '0;
      prev_q     <= '0;
      up_q       <= 1'b0;
      down_q     <= 1'b0;
      err_q      <= 1'b0;
      dout_q     <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      f_q        <= f_d;
      fcnt_q     <= fcnt_d;
      prev_q     <= prev_d;
      up_q       <= up_d;
      down_q     <= down_d;
      err_q      <= err_d;
      dout_q     <= dout_d;
    end
  end

  assign up   = up_q;
  assign down = down_q;
  assign err  = err_q;
  assign dout = dout_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Self-checking bench for quad_decoder: table-driven steps with a pulse scoreboard
// plus hand-written glitch, load-collision and reset sequences.
module tb_quad_decoder;

  typedef enum logic [1:0] {EV_NONE, EV_UP, EV_DOWN, EV_ERR} ev_t;

  typedef struct {
    logic       a;
    logic       b;
    logic       do_load;
    logic [7:0] load_val;
    ev_t        ev;
    logic [7:0] exp_dout;
  } vec_t;

  typedef struct {
    ev_t        ev;
    logic [7:0] dout;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enc_a = 1'b0;
  logic       enc_b = 1'b0;
  logic       load = 1'b0;
  logic [7:0] din = 8'h00;
  logic       up, down, err;
  logic [7:0] dout;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   drive_cyc = 0;
  int   pulse_cyc = 0;
  logic mon_en = 1'b0;
  exp_t exp_q[$];
  exp_t mon_e;
  ev_t  mon_ev;
  vec_t vecs[16];

  quad_decoder #(.DATA_WIDTH(8), .FILTER_CYCLES(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .enc_a (enc_a),
    .enc_b (enc_b),
    .load  (load),
    .din   (din),
    .up    (up),
    .down  (down),
    .err   (err),
    .dout  (dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!rst && mon_en && (up || down || err)) begin
      checkOutput("pulse_onehot", 32'(up) + 32'(down) + 32'(err), 32'd1);
      mon_ev = up ? EV_UP : (down ? EV_DOWN : EV_ERR);
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_pulse", 32'(mon_ev), 32'(EV_NONE));
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("pulse_kind", 32'(mon_ev), 32'(mon_e.ev));
        checkOutput("pulse_dout", 32'(dout), 32'(mon_e.dout));
        pulse_cyc = cyc;
      end
    end
  end

  task automatic waitDrain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
    checkOutput("pulse_arrived", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic doLoad(input logic [7:0] val);
    @(posedge clk);
    #1 load = 1'b1;
    din = val;
    @(posedge clk);
    #1 load = 1'b0;
    @(negedge clk);
    checkOutput("load_dout", 32'(dout), 32'(val));
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    if (v.do_load) doLoad(v.load_val);
    @(posedge clk);
    #1 enc_a = v.a;
    enc_b = v.b;
    drive_cyc = cyc;
    if (v.ev != EV_NONE) begin
      e.ev = v.ev;
      e.dout = v.exp_dout;
      exp_q.push_back(e);
      waitDrain();
      checkOutput("pulse_latency", 32'(pulse_cyc - drive_cyc), 32'd7);
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic glitchA(input int len);
    @(posedge clk);
    #1 enc_a = 1'b1;
    repeat (len) @(posedge clk);
    #1 enc_a = 1'b0;
  endtask

  initial begin
    exp_t e;
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, EV_UP,   8'h01};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 8'h00, EV_UP,   8'h02};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 8'h00, EV_UP,   8'h03};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 8'h00, EV_UP,   8'h04};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 8'h00, EV_UP,   8'h05};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 8'h00, EV_UP,   8'h06};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'h00, EV_UP,   8'h07};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 8'h00, EV_UP,   8'h08};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 8'h00, EV_DOWN, 8'h07};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 8'h00, EV_DOWN, 8'h06};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 8'h00, EV_DOWN, 8'h05};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 8'hFF, EV_UP,   8'h00};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 8'h00, EV_DOWN, 8'hFF};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 8'h00, EV_DOWN, 8'hFE};
    vecs[14] = '{1'b1, 1'b1, 1'b0, 8'h00, EV_ERR,  8'hFE};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 8'h00, EV_UP,   8'hFF};

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_up", 32'(up), 32'd0);
    checkOutput("reset_down", 32'(down), 32'd0);
    checkOutput("reset_err", 32'(err), 32'd0);
    checkOutput("reset_dout", 32'(dout), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;
    repeat (10) @(posedge clk);

    for (int i = 0; i < 14; i++) applyStimulus(vecs[i]);

    // Short glitch must vanish; a minimum-width one counts up and back down.
    glitchA(3);
    repeat (20) @(posedge clk);
    checkOutput("glitch3_dout", 32'(dout), 32'h0FE);
    glitchA(4);
    e.ev = EV_UP;   e.dout = 8'hFF; exp_q.push_back(e);
    e.ev = EV_DOWN; e.dout = 8'hFE; exp_q.push_back(e);
    waitDrain();
    repeat (3) @(posedge clk);
    checkOutput("glitch4_dout", 32'(dout), 32'h0FE);

    for (int i = 14; i < 16; i++) applyStimulus(vecs[i]);

    // Load lands on the same edge that raises up: load wins the count.
    @(posedge clk);
    #1 enc_a = 1'b0;
    enc_b = 1'b0;
    e.ev = EV_UP; e.dout = 8'h40; exp_q.push_back(e);
    @(posedge clk);
    repeat (5) @(posedge clk);
    #1 load = 1'b1;
    din = 8'h40;
    @(posedge clk);
    #1 load = 1'b0;
    waitDrain();
    checkOutput("collide_dout", 32'(dout), 32'h040);
    repeat (3) @(posedge clk);

    // Reset in the middle of filtering a 00->11 change.
    @(posedge clk);
    #1 enc_a = 1'b1;
    enc_b = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_up", 32'(up), 32'd0);
    checkOutput("midrst_down", 32'(down), 32'd0);
    checkOutput("midrst_err", 32'(err), 32'd0);
    checkOutput("midrst_dout", 32'(dout), 32'd0);
    repeat (20) @(posedge clk);
    applyStimulus('{1'b0, 1'b1, 1'b0, 8'h00, EV_UP, 8'h01});
    repeat (10) @(posedge clk);
    checkOutput("final_dout", 32'(dout), 32'h001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
